// File: rtl/run_detect_pkg.sv
// Shared types and constants for the run detector: FSM state encoding and
// the overlap-policy selector values.
package run_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_e;

  localparam int MODE_RESTART = 0;
  localparam int MODE_OVERLAP = 1;
  localparam int MODE_REARM   = 2;

endpackage

// File: rtl/run_detect_sync_if.sv
// Pin-side bundle of the run detector: the raw serial input and clear go in,
// the synchronised input, hit pulse, hit count and saturation flag come out.
interface run_detect_sync_if #(
  parameter int CNT_W = 8
);
  logic             din_async;
  logic             clr;
  logic             din_sync;
  logic             hit;
  logic [CNT_W-1:0] hit_count;
  logic             sat;

  modport master (
    output din_async, clr,
    input  din_sync, hit, hit_count, sat
  );

  modport slave (
    input  din_async, clr,
    output din_sync, hit, hit_count, sat
  );
endinterface

// File: rtl/sync_chain.sv
// N-flop synchroniser for a single asynchronous input, cleared asynchronously.
// Shared by every pin that crosses into the clk domain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: non-blocking assignment makes every stage sample the value its
  // neighbour held before the edge, so the chain shifts by exactly one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/run_detect_sync.sv
// Synchronises one asynchronous pin and detects runs of RUN_LEN ones under a
// selectable overlap policy, producing a hit pulse and a saturating hit count.
module run_detect_sync
  import run_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RUN_LEN     = 3,
  parameter int MODE        = 0,
  parameter int CNT_W       = 8
) (
  input logic             clk,
  input logic             rst_n,
  run_detect_sync_if.slave bus
);

  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("run_detect_sync: SYNC_STAGES must be at least 2");
  end
  if (RUN_LEN < 2) begin : g_bad_run_len
    $error("run_detect_sync: RUN_LEN must be at least 2");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("run_detect_sync: MODE must be 0, 1 or 2");
  end

  logic din_sync;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.din_async),
    .q_o   (din_sync)
  );

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q,   run_d;
  logic             hit_q,   hit_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             sat_q,   sat_d;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    if (!din_sync) begin
      state_d = ST_IDLE;
      run_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (run_q == RUN_LAST) begin
            hit_d = 1'b1;
            if (MODE == MODE_OVERLAP) begin
              state_d = ST_RUN;
              run_d   = RUN_LAST;
            end else if (MODE == MODE_REARM) begin
              state_d = ST_HOLD;
              run_d   = '0;
            end else begin
              state_d = ST_IDLE;
              run_d   = '0;
            end
          end else begin
            state_d = ST_RUN;
            run_d   = run_q + RUN_W'(1);
          end
        end
        ST_HOLD: begin
          state_d = ST_HOLD;
        end
        default: begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      endcase
    end

    // Clear takes priority, so a hit coinciding with clr is not counted.
    if (bus.clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (hit_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
      sat_d = sat_q | (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.din_sync  = din_sync;
  assign bus.hit       = hit_q;
  assign bus.hit_count = cnt_q;
  assign bus.sat       = sat_q;

endmodule
